operand_skew_feeder: RTL

- Parametrised next-generation operand feeder between the operand SRAM bank and one edge of the PE array (A-side or B-side).
- On a start command it generates a burst of K SRAM reads from a base address and captures the LANES-wide read data.
- Each lane's word is reformatted by a per-burst format mode, then skewed so lane i reaches its PE row/column i cycles after lane 0.
- Adds what the previous fixed 8-lane feeder lacked: its own address generation, a burst FSM, last-beat (cmen) tagging, a PE-side stall with SRAM-return capture, and a done handshake.

---
 rtl/operand_skew_feeder.sv | 273 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/operand_skew_feeder.sv
// -----------------------------------------------------------------------------
// operand_skew_feeder
// Streams one burst of operand words from the operand SRAM bank into one edge
// of the PE array. A start command latches a base address, a beat count and a
// format mode. The block then issues consecutive SRAM reads and reformats each
// returned lane word. Lane i of the result is delayed by i cycles, so that the
// data enters the array as a diagonal wavefront.
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-low reset
//   start             one-cycle burst request, honoured only when idle
//   fmt               format mode: 0 PASS, 1 HALF_ZX, 2 BYTE_REP, 3 PAIR_REP
//   base_addr, k_len  first SRAM word address and number of beats
//   stall             PE-side hold: freezes issue, drain count and skew pipe
//   busy, done        burst in progress / one-cycle completion pulse
//   sram_rd_en/addr   read strobe and address; data returns one cycle later
//   sram_rdata        returned data, lane i in bits [i*DW +: DW]
//   pe_data/en/cmen   skewed lane data, lane valid, lane last-beat flag
// -----------------------------------------------------------------------------
module operand_skew_feeder #(
    parameter int LANES = 8,
    parameter int DW    = 32,
    parameter int AW    = 32,
    parameter int KW    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [1:0]          fmt,
    input  logic [AW-1:0]       base_addr,
    input  logic [KW-1:0]       k_len,
    input  logic                stall,
    output logic                busy,
    output logic                done,
    output logic                sram_rd_en,
    output logic [AW-1:0]       sram_addr,
    input  logic [LANES*DW-1:0] sram_rdata,
    output logic [LANES*DW-1:0] pe_data,
    output logic [LANES-1:0]    pe_en,
    output logic [LANES-1:0]    pe_cmen
);

    localparam int CW = $clog2(LANES + 2);
    localparam int NW = LANES * DW;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    // Reformat one lane word; sel picks the upper 16-bit half or byte 1.
    function automatic logic [DW-1:0] format_word(input logic [1:0]    mode,
                                                  input logic          sel,
                                                  input logic [DW-1:0] w);
        logic [DW-1:0] res;
        logic [DW-1:0] shifted;
        logic [7:0]    b;
        res     = '0;
        shifted = sel ? (w >> 16) : w;
        b       = sel ? w[15:8] : w[7:0];
        case (mode)
            2'd0: res = w;
            2'd1: res[15:0] = shifted[15:0];
            2'd2: for (int j = 0; j < DW / 8; j++) res[j*8 +: 8] = b;
            // Bits above the last whole 32-bit slice stay zero.
            2'd3: for (int j = 0; j < DW / 32; j++)
                      res[j*32 +: 32] = {w[15:8], w[15:8], w[7:0], w[7:0]};
            default: res = w;
        endcase
        return res;
    endfunction

    state_e          state_q, state_d;
    logic [1:0]      fmt_q, fmt_d;
    logic [AW-1:0]   base_q, base_d;
    logic [KW-1:0]   klen_q, klen_d;
    logic [KW-1:0]   beat_q, beat_d;
    logic [CW-1:0]   drain_q, drain_d;
    logic            rd_en_s;
    logic [AW-1:0]   addr_s;
    logic            last_s;

    logic            ret_vld_q, ret_cmen_q, ret_sel_q;
    logic            hold_vld_q, hold_cmen_q, hold_sel_q;
    logic [NW-1:0]   hold_data_q;

    logic            ld_vld_s, ld_cmen_s, ld_sel_s;
    logic [NW-1:0]   ld_raw_s, ld_fmt_s;

    logic [LANES-1:0] stg_vld_q;
    logic [LANES-1:0] stg_cmen_q;
    logic [NW-1:0]    stg_data_q [LANES];

    // Burst FSM: next state, read issue, address and last-beat tag.
    always_comb begin
        state_d = state_q;
        fmt_d   = fmt_q;
        base_d  = base_q;
        klen_d  = klen_q;
        beat_d  = beat_q;
        drain_d = drain_q;
        rd_en_s = 1'b0;
        addr_s  = '0;
        last_s  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (k_len != '0) begin
                        fmt_d   = fmt;
                        base_d  = base_addr;
                        klen_d  = k_len;
                        beat_d  = '0;
                        state_d = S_ISSUE;
                    end else begin
                        state_d = S_DONE;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                addr_s  = base_q + AW'(beat_q);
                last_s  = (beat_q == klen_q - KW'(1));
                rd_en_s = !stall;
                if (!stall) begin
                    if (last_s) begin
                        state_d = S_DRAIN;
                        drain_d = '0;
                    end else begin
                        beat_d = beat_q + KW'(1);
                    end
                end else begin
                    beat_d = beat_q;
                end
            end
            // LANES+1 unstalled cycles flush the return stage and the skew pipe.
            S_DRAIN: begin
                if (!stall) begin
                    if (drain_q == CW'(LANES)) begin
                        state_d = S_DONE;
                        drain_d = '0;
                    end else begin
                        drain_d = drain_q + CW'(1);
                    end
                end else begin
                    drain_d = drain_q;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FSM state and latched burst parameters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            fmt_q   <= 2'd0;
            base_q  <= '0;
            klen_q  <= '0;
            beat_q  <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            fmt_q   <= fmt_d;
            base_q  <= base_d;
            klen_q  <= klen_d;
            beat_q  <= beat_d;
            drain_q <= drain_d;
        end
    end

    // Tag travelling with each read, aligned with the returning SRAM data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ret_vld_q  <= 1'b0;
            ret_cmen_q <= 1'b0;
            ret_sel_q  <= 1'b0;
        end else begin
            ret_vld_q  <= rd_en_s;
            ret_cmen_q <= last_s;
            ret_sel_q  <= addr_s[1];
        end
    end

    // One-entry hold for data that returns while the PE side is stalled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_vld_q  <= 1'b0;
            hold_cmen_q <= 1'b0;
            hold_sel_q  <= 1'b0;
            hold_data_q <= '0;
        end else if (stall && ret_vld_q) begin
            hold_vld_q  <= 1'b1;
            hold_cmen_q <= ret_cmen_q;
            hold_sel_q  <= ret_sel_q;
            hold_data_q <= sram_rdata;
        end else if (!stall) begin
            hold_vld_q  <= 1'b0;
        end
    end

    // Lane-0 stage source (live return or held word) and per-lane formatting.
    always_comb begin
        ld_vld_s  = 1'b0;
        ld_cmen_s = 1'b0;
        ld_sel_s  = 1'b0;
        ld_raw_s  = '0;
        ld_fmt_s  = '0;
        if (ret_vld_q) begin
            ld_vld_s  = 1'b1;
            ld_cmen_s = ret_cmen_q;
            ld_sel_s  = ret_sel_q;
            ld_raw_s  = sram_rdata;
        end else if (hold_vld_q) begin
            ld_vld_s  = 1'b1;
            ld_cmen_s = hold_cmen_q;
            ld_sel_s  = hold_sel_q;
            ld_raw_s  = hold_data_q;
        end else begin
            ld_vld_s  = 1'b0;
        end
        for (int l = 0; l < LANES; l++) begin
            ld_fmt_s[l*DW +: DW] = format_word(fmt_q, ld_sel_s, ld_raw_s[l*DW +: DW]);
        end
    end

    // Skew pipeline: stage j feeds lane j; data only moves with a valid beat.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stg_vld_q  <= '0;
            stg_cmen_q <= '0;
            for (int j = 0; j < LANES; j++) begin
                stg_data_q[j] <= '0;
            end
        end else if (!stall) begin
            stg_vld_q[0]  <= ld_vld_s;
            stg_cmen_q[0] <= ld_vld_s & ld_cmen_s;
            if (ld_vld_s) begin
                stg_data_q[0] <= ld_fmt_s;
            end
            for (int j = 1; j < LANES; j++) begin
                stg_vld_q[j]  <= stg_vld_q[j-1];
                stg_cmen_q[j] <= stg_cmen_q[j-1];
                if (stg_vld_q[j-1]) begin
                    stg_data_q[j] <= stg_data_q[j-1];
                end
            end
        end
    end

    // Lane i output is taken from its own slice of skew stage i.
    always_comb begin
        pe_data = '0;
        for (int l = 0; l < LANES; l++) begin
            pe_data[l*DW +: DW] = stg_data_q[l][l*DW +: DW];
        end
    end

    assign pe_en      = stg_vld_q;
    assign pe_cmen    = stg_cmen_q;
    assign sram_rd_en = rd_en_s;
    assign sram_addr  = addr_s;
    assign busy       = (state_q == S_ISSUE) || (state_q == S_DRAIN);
    assign done       = (state_q == S_DONE);

endmodule
